// File: rtl/compute_engine_p_pkg.sv
// compute_engine_p_pkg: shared constants for the 8-lane dot-product engine
//   LANES : number of feature/weight lanes
//   DEPTH : pipeline depth (multiply, pair add, final add)
package compute_engine_p_pkg;
  localparam int LANES = 8;
  localparam int DEPTH = 3;
endpackage

// File: rtl/compute_engine_p_pe_mult.sv
// pe_mult: registered signed multiplier producing a 2*DATA_WIDTH product
//   clk, rst_n : clock, async active-low reset
//   a, b       : signed operands
//   p          : registered product a*b
module pe_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);
  // Sign-extending both operands to full width makes the unsigned product
  // congruent to the signed one modulo 2^(2*DATA_WIDTH).
  logic [2*DATA_WIDTH-1:0] ax, bx;
  assign ax = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign bx = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else p <= ax * bx;
endmodule

// File: rtl/compute_engine_p.sv
// compute_engine_p: 3-stage pipelined 8-lane signed dot product
//   clk, rst_n                 : clock, async active-low reset
//   input_channel_done         : controller flag, not used here
//   output_channel_done        : controller flag, not used here
//   input_channel_sel          : input-channel block base index
//   output_channel_sel         : output-channel block base index
//   input_feature, weight_line : 8 signed lanes each
//   result                     : dot product, wraps mod 2^(2*DATA_WIDTH)
//   *_sel_delay3               : sel inputs aligned with result
module compute_engine_p
  import compute_engine_p_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        input_channel_done,
  input  logic                        output_channel_done,
  input  logic [7:0]                  input_channel_sel,
  input  logic [7:0]                  output_channel_sel,
  input  logic [DATA_WIDTH*LANES-1:0] input_feature,
  input  logic [DATA_WIDTH*LANES-1:0] weight_line,
  output logic [DATA_WIDTH*2-1:0]     result,
  output logic [7:0]                  input_channel_sel_delay3,
  output logic [7:0]                  output_channel_sel_delay3
);
  localparam int PW = DATA_WIDTH * 2;
  logic unused_done;
  assign unused_done = input_channel_done ^ output_channel_done;
  logic [PW-1:0] prod [LANES];
  logic [PW-1:0] pair [LANES/2];
  logic [7:0] isel_d [DEPTH];
  logic [7:0] osel_d [DEPTH];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pe_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (input_feature[k*DATA_WIDTH +: DATA_WIDTH]),
      .b    (weight_line[k*DATA_WIDTH +: DATA_WIDTH]),
      .p    (prod[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int j = 0; j < LANES/2; j++) pair[j] <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        isel_d[j] <= '0;
        osel_d[j] <= '0;
      end
      result <= '0;
    end else begin
      for (int j = 0; j < LANES/2; j++) pair[j] <= prod[2*j] + prod[2*j+1];
      isel_d[0] <= input_channel_sel;
      osel_d[0] <= output_channel_sel;
      for (int j = 1; j < DEPTH; j++) begin
        isel_d[j] <= isel_d[j-1];
        osel_d[j] <= osel_d[j-1];
      end
      result <= (pair[0] + pair[1]) + (pair[2] + pair[3]);
    end
  assign input_channel_sel_delay3  = isel_d[DEPTH-1];
  assign output_channel_sel_delay3 = osel_d[DEPTH-1];
endmodule

// File: tb/tb_compute_engine_p.sv
// tb_compute_engine_p: directed-vector bench for compute_engine_p
module tb_compute_engine_p;
  logic clk = 0;
  logic rst_n = 0;
  logic icd = 0, ocd = 0;
  logic [7:0] isel = 0, osel = 0;
  logic [63:0] feat = 0, wgt = 0;
  logic [15:0] result;
  logic [7:0] isel_d3, osel_d3;
  int vecs = 0, errs = 0;
  compute_engine_p #(.DATA_WIDTH(8)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .input_channel_done       (icd),
    .output_channel_done      (ocd),
    .input_channel_sel        (isel),
    .output_channel_sel       (osel),
    .input_feature            (feat),
    .weight_line              (wgt),
    .result                   (result),
    .input_channel_sel_delay3 (isel_d3),
    .output_channel_sel_delay3(osel_d3)
  );
  always #5 clk = ~clk;
  localparam logic [63:0] RAMP = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic done_bits(input bit tog);
    icd = tog ? 1'($urandom) : 1'b0;
    ocd = tog ? 1'($urandom) : 1'b0;
  endtask
  task automatic stream(input bit tog);
    feat = rep(8'd1); wgt = rep(8'd1); isel = 8'h01; osel = 8'h00; done_bits(tog);
    tick();
    feat = RAMP; wgt = rep(8'hFF); isel = 8'h02; osel = 8'h08; done_bits(tog);
    tick();
    feat = rep(8'd2); wgt = rep(8'd3); isel = 8'h03; osel = 8'h10; done_bits(tog);
    tick();
    chk("stream_v0_result", result, 16'h0008);
    chk("stream_v0_osel", {8'h0, osel_d3}, 16'h0000);
    chk("stream_v0_isel", {8'h0, isel_d3}, 16'h0001);
    feat = 0; wgt = 0; isel = 0; osel = 0; done_bits(tog);
    tick();
    chk("stream_v1_result", result, 16'hFFDC);
    chk("stream_v1_osel", {8'h0, osel_d3}, 16'h0008);
    chk("stream_v1_isel", {8'h0, isel_d3}, 16'h0002);
    done_bits(tog);
    tick();
    chk("stream_v2_result", result, 16'h0030);
    chk("stream_v2_osel", {8'h0, osel_d3}, 16'h0010);
    chk("stream_v2_isel", {8'h0, isel_d3}, 16'h0003);
    icd = 0; ocd = 0;
  endtask
  initial begin
    feat = rep(8'd1); wgt = rep(8'd1); isel = 8'hAA; osel = 8'h55;
    #12;
    chk("reset_result", result, 16'h0000);
    chk("reset_isel", {8'h0, isel_d3}, 16'h0000);
    chk("reset_osel", {8'h0, osel_d3}, 16'h0000);
    #1 rst_n = 1;
    tick();
    chk("latency_edge0", result, 16'h0000);
    tick();
    chk("latency_edge1", result, 16'h0000);
    chk("latency_sel_edge1", {8'h0, isel_d3}, 16'h0000);
    tick();
    chk("ones_result", result, 16'h0008);
    chk("ones_isel", {8'h0, isel_d3}, 16'h00AA);
    chk("ones_osel", {8'h0, osel_d3}, 16'h0055);
    tick();
    chk("ones_held", result, 16'h0008);
    feat = rep(8'h80); wgt = rep(8'h80);
    tick(); tick(); tick();
    chk("wrap_neg128", result, 16'h0000);
    feat = RAMP; wgt = rep(8'hFF);
    tick(); tick(); tick();
    chk("ramp_neg1", result, 16'hFFDC);
    feat = rep(8'h7F); wgt = rep(8'h80);
    tick(); tick(); tick();
    chk("mixed_127x-128", result, 16'h0400);
    stream(1'b0);
    stream(1'b1);
    feat = rep(8'd1); wgt = rep(8'd1); isel = 8'h11; osel = 8'h22;
    tick(); tick(); tick();
    chk("pre_reset_result", result, 16'h0008);
    #2 rst_n = 0;
    #1;
    chk("async_reset_result", result, 16'h0000);
    chk("async_reset_isel", {8'h0, isel_d3}, 16'h0000);
    chk("async_reset_osel", {8'h0, osel_d3}, 16'h0000);
    feat = 0; wgt = 0; isel = 0; osel = 0;
    #3 rst_n = 1;
    tick();
    chk("post_reset_discard", result, 16'h0000);
    chk("post_reset_isel", {8'h0, isel_d3}, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
